// File: rtl/ftm_nmr.sv
// N-modular-redundancy fault-tolerance manager: votes or compares per-core register write-back,
// checkpoints the last clean PC and sequences core reset/recovery with retry and timeout limits.
module ftm_nmr #(
  parameter int NUM_CORES       = 3,
  parameter int ADDR_WIDTH      = 5,
  parameter int DATA_WIDTH      = 32,
  parameter int FAULT_THRESHOLD = 4,
  parameter int MAX_RETRIES     = 3,
  parameter int RESET_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             enable_i,
  input  logic                             mode_i,
  input  logic                             valid_i,
  input  logic [NUM_CORES-1:0]             we_i,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  data_i,
  input  logic [DATA_WIDTH-1:0]            pc_i,
  input  logic                             done_i,
  input  logic                             clr_i,
  output logic                             we_o,
  output logic [ADDR_WIDTH-1:0]            addr_o,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic [DATA_WIDTH-1:0]            ckpt_pc_o,
  output logic [NUM_CORES-1:0]             faulty_o,
  output logic                             corr_err_o,
  output logic                             reset_no,
  output logic                             recover_o,
  output logic                             recovering_o,
  output logic                             load_pc_o,
  output logic                             fail_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RESET, ST_RECOVER, ST_FAIL} state_t;

  localparam int CNT_W = $clog2(FAULT_THRESHOLD + 1);
  localparam int RTY_W = $clog2(MAX_RETRIES + 1);
  localparam int TIM_W = $clog2((TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES) + 1;
  // Third-core index; aliases core 1 in a two-core build, where TMR is never selected.
  localparam int C2    = (NUM_CORES > 2) ? 2 : 1;

  localparam logic [CNT_W-1:0] THR      = CNT_W'(FAULT_THRESHOLD);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
  localparam logic [TIM_W-1:0] RST_LAST = TIM_W'(RESET_CYCLES - 1);
  localparam logic [TIM_W-1:0] TO_LAST  = TIM_W'(TIMEOUT_CYCLES - 1);

  function automatic logic tuple_eq(input logic wa, input logic [ADDR_WIDTH-1:0] aa,
                                    input logic [DATA_WIDTH-1:0] da, input logic wb,
                                    input logic [ADDR_WIDTH-1:0] ab, input logic [DATA_WIDTH-1:0] db);
    return (!wa && !wb) || (wa && wb && (aa == ab) && (da == db));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
    return (c == THR) ? c : c + 1'b1;
  endfunction

  function automatic logic [RTY_W-1:0] sat_inc_rty(input logic [RTY_W-1:0] c);
    return (c == RTY_MAX) ? c : c + 1'b1;
  endfunction

  logic [ADDR_WIDTH-1:0] addr_c [NUM_CORES];
  logic [DATA_WIDTH-1:0] data_c [NUM_CORES];

  state_t                 state_q, state_d;
  logic [TIM_W-1:0]       timer_q, timer_d;
  logic [RTY_W-1:0]       retry_q, retry_d;
  logic [CNT_W-1:0]       cnt_q [NUM_CORES];
  logic [CNT_W-1:0]       cnt_d [NUM_CORES];
  logic [NUM_CORES-1:0]   faulty_q, faulty_d;
  logic                   corr_q, corr_d;
  logic [DATA_WIDTH-1:0]  ckpt_q, ckpt_d;
  logic                   reset_n_q, reset_n_d;
  logic                   recover_q, recover_d;
  logic                   recovering_q, recovering_d;
  logic                   load_pc_q, load_pc_d;
  logic                   fail_q, fail_d;

  logic                   tmr, check, idle, unc, corr, sel1, thr_hit;
  logic                   eq01, eq02, eq12;
  logic [NUM_CORES-1:0]   dissent;

  always_comb begin
    for (int k = 0; k < NUM_CORES; k++) begin
      addr_c[k] = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      data_c[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Voter: zero-latency path from the core write ports to the trusted write port.
  always_comb begin
    tmr     = (NUM_CORES == 3) && mode_i;
    idle    = (state_q == ST_IDLE);
    check   = enable_i && valid_i && idle;
    eq01    = tuple_eq(we_i[0], addr_c[0], data_c[0], we_i[1], addr_c[1], data_c[1]);
    eq02    = tuple_eq(we_i[0], addr_c[0], data_c[0], we_i[C2], addr_c[C2], data_c[C2]);
    eq12    = tuple_eq(we_i[1], addr_c[1], data_c[1], we_i[C2], addr_c[C2], data_c[C2]);
    unc     = 1'b0;
    corr    = 1'b0;
    sel1    = 1'b0;
    dissent = '0;
    if (check) begin
      if (!tmr) begin
        unc = !eq01;
      end else if (!(eq01 && eq02)) begin
        // Equality is transitive, so a single true pair identifies the lone dissenter.
        if (eq01) begin
          corr        = 1'b1;
          dissent[C2] = 1'b1;
        end else if (eq02) begin
          corr       = 1'b1;
          dissent[1] = 1'b1;
        end else if (eq12) begin
          corr       = 1'b1;
          dissent[0] = 1'b1;
          sel1       = 1'b1;
        end else begin
          unc = 1'b1;
        end
      end
    end
    we_o   = idle && !unc && (sel1 ? we_i[1] : we_i[0]);
    addr_o = idle ? (sel1 ? addr_c[1] : addr_c[0]) : '0;
    data_o = idle ? (sel1 ? data_c[1] : data_c[0]) : '0;
  end

  always_comb begin
    thr_hit = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (cnt_q[k] == THR) thr_hit = 1'b1;
    end
  end

  // Next-state: recovery sequencer, counters and checkpoint.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    faulty_d = faulty_q;
    corr_d   = corr;
    ckpt_d   = ckpt_q;
    if (check && !unc) ckpt_d = pc_i;
    case (state_q)
      ST_IDLE: begin
        for (int k = 0; k < NUM_CORES; k++) begin
          if (dissent[k]) cnt_d[k] = sat_inc_cnt(cnt_q[k]);
        end
        faulty_d = faulty_q | dissent;
        if (clr_i) begin
          retry_d  = '0;
          faulty_d = '0;
          for (int k = 0; k < NUM_CORES; k++) cnt_d[k] = '0;
        end
        // The trigger decision uses the pre-clear retry count.
        if (unc || thr_hit) begin
          timer_d = '0;
          state_d = (retry_q == RTY_MAX) ? ST_FAIL : ST_RESET;
        end
      end
      ST_RESET: begin
        if (timer_q == RST_LAST) begin
          timer_d = '0;
          state_d = ST_RECOVER;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RECOVER: begin
        if (done_i) begin
          state_d  = ST_IDLE;
          retry_d  = sat_inc_rty(retry_q);
          faulty_d = '0;
          for (int k = 0; k < NUM_CORES; k++) cnt_d[k] = '0;
        end else if (timer_q == TO_LAST) begin
          state_d = ST_FAIL;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_FAIL: begin
        if (clr_i) begin
          state_d  = ST_IDLE;
          retry_d  = '0;
          faulty_d = '0;
          for (int k = 0; k < NUM_CORES; k++) cnt_d[k] = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    reset_n_d    = !((state_d == ST_RESET) || (state_d == ST_FAIL));
    recovering_d = (state_d == ST_RESET) || (state_d == ST_RECOVER);
    load_pc_d    = (state_d == ST_RECOVER);
    recover_d    = (state_d == ST_RECOVER) && (state_q != ST_RECOVER);
    fail_d       = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      for (int k = 0; k < NUM_CORES; k++) cnt_q[k] <= '0;
      faulty_q     <= '0;
      corr_q       <= 1'b0;
      ckpt_q       <= '0;
      reset_n_q    <= 1'b1;
      recover_q    <= 1'b0;
      recovering_q <= 1'b0;
      load_pc_q    <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      cnt_q        <= cnt_d;
      faulty_q     <= faulty_d;
      corr_q       <= corr_d;
      ckpt_q       <= ckpt_d;
      reset_n_q    <= reset_n_d;
      recover_q    <= recover_d;
      recovering_q <= recovering_d;
      load_pc_q    <= load_pc_d;
      fail_q       <= fail_d;
    end
  end

  assign ckpt_pc_o    = ckpt_q;
  assign faulty_o     = faulty_q;
  assign corr_err_o   = corr_q;
  assign reset_no     = reset_n_q;
  assign recover_o    = recover_q;
  assign recovering_o = recovering_q;
  assign load_pc_o    = load_pc_q;
  assign fail_o       = fail_q;

endmodule

// File: tb/tb_ftm_nmr.sv
// Directed bench for ftm_nmr: vote/compare vector table plus recovery, retry, timeout and reset sequences.
module tb_ftm_nmr;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i, mode_i, valid_i, done_i, clr_i;
  logic [2:0]  we_i;
  logic [14:0] addr_i;
  logic [95:0] data_i;
  logic [31:0] pc_i;
  logic        we_o;
  logic [4:0]  addr_o;
  logic [31:0] data_o, ckpt_pc_o;
  logic [2:0]  faulty_o;
  logic        corr_err_o, reset_no, recover_o, recovering_o, load_pc_o, fail_o;

  int errors = 0;
  int checks = 0;

  ftm_nmr dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .mode_i(mode_i), .valid_i(valid_i),
    .we_i(we_i), .addr_i(addr_i), .data_i(data_i), .pc_i(pc_i), .done_i(done_i), .clr_i(clr_i),
    .we_o(we_o), .addr_o(addr_o), .data_o(data_o), .ckpt_pc_o(ckpt_pc_o), .faulty_o(faulty_o),
    .corr_err_o(corr_err_o), .reset_no(reset_no), .recover_o(recover_o),
    .recovering_o(recovering_o), .load_pc_o(load_pc_o), .fail_o(fail_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        mode, en, vld;
    logic [2:0]  we;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2, pc;
    logic        ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [2:0]  ef;
    logic        ec;
    logic [31:0] ek;
  } vec_t;

  vec_t vt[10];

  function automatic vec_t mk(logic mode, logic en, logic vld, logic [2:0] we,
                              logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic [31:0] pc,
                              logic ewe, logic [4:0] ea, logic [31:0] ed,
                              logic [2:0] ef, logic ec, logic [31:0] ek);
    vec_t v;
    v.mode = mode; v.en = en; v.vld = vld; v.we = we;
    v.a0 = a0; v.a1 = a1; v.a2 = a2; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.pc = pc;
    v.ewe = ewe; v.ea = ea; v.ed = ed; v.ef = ef; v.ec = ec; v.ek = ek;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic mode, input logic en, input logic vld, input logic [2:0] we,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] pc);
    mode_i = mode; enable_i = en; valid_i = vld; we_i = we;
    addr_i = {a2, a1, a0}; data_i = {d2, d1, d0}; pc_i = pc;
  endtask

  task automatic quiet();
    valid_i = 1'b0; we_i = 3'b000; addr_i = '0; data_i = '0;
  endtask

  // Entered in the first RESET cycle; returns in the first RECOVER cycle.
  task automatic wait_reset(input string tag);
    int lows = 0;
    while (reset_no == 1'b0 && lows < 50) begin
      lows++;
      step();
    end
    chk({tag, "_reset_low_cycles"}, lows, 4);
  endtask

  task automatic run_recovery(input int done_after, input logic [31:0] exp_ckpt, input string tag);
    int pulses = 0;
    wait_reset(tag);
    chk({tag, "_load_pc"}, load_pc_o, 1);
    chk({tag, "_ckpt_hold"}, ckpt_pc_o, exp_ckpt);
    for (int i = 1; i <= done_after; i++) begin
      pulses += int'(recover_o);
      if (i == done_after) done_i = 1'b1;
      step();
    end
    done_i = 1'b0;
    chk({tag, "_recover_pulses"}, pulses, 1);
    chk({tag, "_exit_recovering"}, recovering_o, 0);
    chk({tag, "_exit_faulty"}, faulty_o, 0);
  endtask

  task automatic trigger_unc();
    drive(1, 1, 1, 3'b111, 1, 2, 3, 32'h10, 32'h20, 32'h30, 32'h900);
    #1;
    chk("unc_we_blocked", we_o, 0);
    step();
    quiet();
  endtask

  initial begin
    rst_ni = 1'b0; done_i = 1'b0; clr_i = 1'b0; enable_i = 1'b1; mode_i = 1'b1;
    pc_i = '0;
    quiet();

    vt[0] = mk(1,1,1,3'b111, 5,5,5, 32'hA5A5A5A5,32'hA5A5A5A5,32'hA5A5A5A5, 32'h100, 1,5,32'hA5A5A5A5, 3'b000,0,32'h100);
    vt[1] = mk(1,1,1,3'b111, 3,3,3, 32'h1234,32'h1234,32'hDEAD, 32'h104, 1,3,32'h1234, 3'b100,1,32'h104);
    vt[2] = mk(1,1,1,3'b111, 4,9,4, 32'h77,32'h77,32'h77, 32'h108, 1,4,32'h77, 3'b010,1,32'h108);
    vt[3] = mk(1,1,1,3'b111, 6,6,6, 32'h1,32'h2,32'h2, 32'h10C, 1,6,32'h2, 3'b001,1,32'h10C);
    vt[4] = mk(1,1,1,3'b000, 1,2,3, 32'h5,32'h6,32'h7, 32'h110, 0,1,32'h5, 3'b000,0,32'h110);
    vt[5] = mk(1,1,1,3'b011, 8,8,8, 32'h9,32'h9,32'h9, 32'h114, 1,8,32'h9, 3'b100,1,32'h114);
    vt[6] = mk(1,0,1,3'b111, 1,2,3, 32'h10,32'h20,32'h30, 32'h118, 1,1,32'h10, 3'b000,0,32'h114);
    vt[7] = mk(1,1,0,3'b001, 2,4,6, 32'h3,32'h5,32'h7, 32'h11C, 1,2,32'h3, 3'b000,0,32'h114);
    vt[8] = mk(0,1,1,3'b111, 7,7,9, 32'h55,32'h55,32'h66, 32'h120, 1,7,32'h55, 3'b000,0,32'h120);
    vt[9] = mk(1,1,1,3'b110, 2,2,2, 32'h8,32'h8,32'h8, 32'h124, 1,2,32'h8, 3'b001,1,32'h124);

    #12;
    chk("rst_we", we_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_ckpt", ckpt_pc_o, 0);
    chk("rst_faulty", faulty_o, 0);
    chk("rst_corr", corr_err_o, 0);
    chk("rst_reset_no", reset_no, 1);
    chk("rst_recover", recover_o, 0);
    chk("rst_recovering", recovering_o, 0);
    chk("rst_load_pc", load_pc_o, 0);
    chk("rst_fail", fail_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].mode, vt[i].en, vt[i].vld, vt[i].we, vt[i].a0, vt[i].a1, vt[i].a2,
            vt[i].d0, vt[i].d1, vt[i].d2, vt[i].pc);
      #1;
      chk($sformatf("v%0d_we", i), we_o, vt[i].ewe);
      chk($sformatf("v%0d_addr", i), addr_o, vt[i].ea);
      chk($sformatf("v%0d_data", i), data_o, vt[i].ed);
      step();
      quiet();
      clr_i = 1'b1;
      chk($sformatf("v%0d_faulty", i), faulty_o, vt[i].ef);
      chk($sformatf("v%0d_corr", i), corr_err_o, vt[i].ec);
      chk($sformatf("v%0d_ckpt", i), ckpt_pc_o, vt[i].ek);
      step();
      clr_i = 1'b0;
    end

    // Repeated single-core dissent reaches the threshold and forces a resync.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 3'b111, 3, 3, 3, 32'h1234, 32'h1234, 32'hDEAD, 32'h200 + 4*i);
      #1;
      chk($sformatf("thr%0d_data", i), data_o, 32'h1234);
      step();
      chk($sformatf("thr%0d_corr", i), corr_err_o, 1);
    end
    quiet();
    chk("thr_faulty", faulty_o, 3'b100);
    chk("thr_still_idle", reset_no, 1);
    step();
    chk("thr_enter_reset", reset_no, 0);
    chk("thr_recovering", recovering_o, 1);
    run_recovery(10, 32'h20C, "thr");

    // DMR address mismatch is uncorrectable.
    drive(0, 1, 1, 3'b011, 3, 7, 0, 32'h11, 32'h11, 32'h0, 32'h300);
    #1;
    chk("dmr_we_blocked", we_o, 0);
    step();
    quiet();
    chk("dmr_enter_reset", reset_no, 0);
    chk("dmr_ckpt_kept", ckpt_pc_o, 32'h20C);
    run_recovery(3, 32'h20C, "dmr");

    // Retry exhaustion: clear retries, then three recoveries and a fourth trigger to FAIL.
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    for (int t = 0; t < 4; t++) begin
      trigger_unc();
      if (t < 3) begin
        chk($sformatf("rty%0d_reset", t), reset_no, 0);
        chk($sformatf("rty%0d_nofail", t), fail_o, 0);
        run_recovery(2, 32'h20C, $sformatf("rty%0d", t));
      end else begin
        chk("rty3_fail", fail_o, 1);
        chk("rty3_reset_no", reset_no, 0);
      end
    end
    drive(1, 1, 1, 3'b111, 4, 4, 4, 32'h44, 32'h44, 32'h44, 32'h500);
    #1;
    chk("fail_we_blocked", we_o, 0);
    step(); step(); step();
    chk("fail_sticky", fail_o, 1);
    quiet();
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    chk("clr_fail_cleared", fail_o, 0);
    chk("clr_reset_no", reset_no, 1);
    trigger_unc();
    chk("clr_retry_zero_reset", reset_no, 0);
    chk("clr_retry_zero_nofail", fail_o, 0);

    // Recovery timeout with done_i held low.
    begin
      int n = 0;
      wait_reset("to");
      while (load_pc_o && n < 400) begin
        n++;
        step();
      end
      chk("to_recover_cycles", n, 256);
      chk("to_fail", fail_o, 1);
    end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;

    // done_i on the final permitted cycle wins over the timeout.
    trigger_unc();
    wait_reset("to2");
    for (int i = 1; i <= 256; i++) begin
      if (i == 256) done_i = 1'b1;
      step();
    end
    done_i = 1'b0;
    chk("to2_nofail", fail_o, 0);
    chk("to2_load_pc", load_pc_o, 0);
    chk("to2_reset_no", reset_no, 1);

    // Asynchronous reset in the middle of RESET.
    drive(1, 1, 1, 3'b111, 2, 2, 2, 32'h66, 32'h66, 32'h66, 32'h400);
    step();
    quiet();
    chk("ar_ckpt_before", ckpt_pc_o, 32'h400);
    trigger_unc();
    chk("ar_in_reset", reset_no, 0);
    step();
    #3;
    rst_ni = 1'b0;
    #1;
    chk("ar_reset_no", reset_no, 1);
    chk("ar_recovering", recovering_o, 0);
    chk("ar_ckpt_lost", ckpt_pc_o, 0);
    chk("ar_fail", fail_o, 0);
    chk("ar_load_pc", load_pc_o, 0);
    chk("ar_faulty", faulty_o, 0);
    #2;
    rst_ni = 1'b1;
    step();
    chk("ar_after_release", reset_no, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ftm_nmr.md
Name: ftm_nmr

Overview:
- Parametrised successor to the dual-core fault-tolerance manager. Supports DMR or TMR lockstep.
- Compares or votes the register-file write-back of NUM_CORES redundant cores and forwards a single trusted write to the safe register memory.
- Checkpoints the PC of the last clean commit.
- Sequences reset/recovery with retry limiting, recovery timeout and a sticky fatal state.

Parameters:
NUM_CORES, 3, number of redundant cores; legal values 2 or 3
ADDR_WIDTH, 5, register-file address width
DATA_WIDTH, 32, write data and PC width
FAULT_THRESHOLD, 4, per-core corrected-mismatch count that forces a resync
MAX_RETRIES, 3, recoveries allowed before FAIL
RESET_CYCLES, 4, cycles reset_no is held low per recovery
TIMEOUT_CYCLES, 256, maximum cycles in RECOVER waiting for done_i

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  comparison enable; when low no errors are flagged and writes pass from core 0
mode_i  in  1  0=DMR on cores 0/1, 1=TMR; ignored (forced 0) when NUM_CORES=2
valid_i  in  1  core-0 valid retired instruction this cycle
we_i  in  NUM_CORES  per-core write enable
addr_i  in  NUM_CORES*ADDR_WIDTH  per-core write address, core k in slice k
data_i  in  NUM_CORES*DATA_WIDTH  per-core write data
pc_i  in  DATA_WIDTH  core-0 PC of the retiring instruction
done_i  in  1  recovery-routine complete
clr_i  in  1  clears counters and the FAIL state (software acknowledge)
we_o  out  1  trusted write enable to the safe RF
addr_o  out  ADDR_WIDTH  trusted address
data_o  out  DATA_WIDTH  trusted data
ckpt_pc_o  out  DATA_WIDTH  checkpointed PC
faulty_o  out  NUM_CORES  per-core dissent flag, registered
corr_err_o  out  1  one-cycle pulse on a corrected (masked) mismatch
reset_no  out  1  core reset, active low
recover_o  out  1  one-cycle pulse on entry to RECOVER
recovering_o  out  1  high throughout RESET and RECOVER
load_pc_o  out  1  high in RECOVER; core loads ckpt_pc_o
fail_o  out  1  sticky unrecoverable fault

Behaviour:
- Reset values: we_o=0, addr_o=0, data_o=0, ckpt_pc_o=0, faulty_o=0, corr_err_o=0, reset_no=1, recover_o=0, recovering_o=0, load_pc_o=0, fail_o=0. All counters are 0 and the FSM is in IDLE.
- Tuple equality: core tuple T_k={we,addr,data}. Two tuples are equal if both we are 0, or both we are 1 with matching addr and data.
- Checking: only when enable_i & valid_i & state==IDLE. Otherwise there is no error and outputs follow core 0, gated by state==IDLE.
- DMR, T0==T1: pass T0.
- DMR, T0!=T1: uncorrectable; we_o=0.
- TMR, all equal: pass T0.
- TMR, exactly one core dissents: pass the majority tuple. faulty_o sets that core's bit next cycle. corr_err_o pulses. That core's saturating counter increments.
- TMR, all three differ: uncorrectable; we_o=0.
- Voting latency: we_o/addr_o/data_o are combinational from the inputs (zero latency). Error detection, flags and counters are registered, so the FSM reacts on the next edge.
- Checkpoint: ckpt_pc_o<=pc_i on any checked cycle with no uncorrectable error.
- FSM states: IDLE, RESET, RECOVER, FAIL.
- IDLE->RESET on an uncorrectable error, or when any core counter reaches FAULT_THRESHOLD.
- IDLE->FAIL instead of RESET if the trigger arrives with retry_cnt==MAX_RETRIES.
- RESET: reset_no=0 for exactly RESET_CYCLES cycles, then ->RECOVER.
- RECOVER: recover_o pulses in the first cycle; load_pc_o=1 throughout.
- RECOVER->IDLE when done_i=1, sampled in any RECOVER cycle including the first. On that exit, retry_cnt++ (saturating), all per-core counters clear, faulty_o clears.
- RECOVER->FAIL if done_i is still 0 after TIMEOUT_CYCLES cycles.
- FAIL: fail_o=1, we_o=0, reset_no=0. Leaves only on clr_i or rst_ni.
- clr_i in FAIL: ->IDLE next cycle, fail_o=0.
- clr_i in IDLE: clears retry_cnt, per-core counters and faulty_o.
- clr_i in RESET/RECOVER: ignored.
- Simultaneous trigger and clr_i in IDLE: the trigger wins; counters still clear.
- Simultaneous done_i and the timeout expiry: done_i wins.
- Async reset mid-recovery: everything returns to reset values immediately; ckpt_pc_o is lost (0).

Test Plan:
- TMR, three equal writes (we=1, addr=5, data=0xA5A5A5A5) with valid_i=1 -> same-cycle we_o=1, addr_o=5, data_o=0xA5A5A5A5; ckpt_pc_o=pc_i next cycle; no flags.
- TMR, core 2 data=0xDEAD, others 0x1234 -> data_o=0x1234; next cycle faulty_o=3'b100 and corr_err_o pulses. Repeat 4 times -> RESET entered; reset_no low for exactly 4 cycles; then recover_o pulses once and load_pc_o=1; done_i after 10 cycles -> IDLE, faulty_o=0.
- DMR, addr differs (3 vs 7) -> we_o=0 that cycle; RESET next edge; ckpt_pc_o holds the last clean PC during load_pc_o.
- Four consecutive uncorrectable errors, each recovered with done_i -> the fourth trigger goes to FAIL. fail_o=1, we_o=0. clr_i -> IDLE, fail_o=0, retry_cnt=0.
- RECOVER with done_i held 0 -> FAIL after exactly 256 cycles. With done_i=1 on cycle 256 -> IDLE instead.
- Assert rst_ni low during RESET -> all outputs at reset values asynchronously. enable_i=0 with mismatching cores -> no error; we_o follows core 0.
